// File: rtl/fifo_push_arbiter.sv
// Arbitrates N producers onto one FIFO push port: round-robin with bounded burst ownership,
// zero-latency grant, stall on fifo_full, and per-requester accepted-word counters.
module fifo_push_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned BURST_LEN = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      req_data,
  output logic [N-1:0]         gnt,
  input  logic                 fifo_full,
  output logic                 fifo_push,
  output logic [DW-1:0]        fifo_data,
  output logic [2:0]           owner_id,
  output logic                 owner_valid,
  output logic [N*CNT_W-1:0]   push_count
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CW    = 4;

  typedef enum logic {IDLE, OWN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]   acc_q [N];

  logic               owner_req;
  logic               owner_fav;
  logic               scan_found;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   win_idx;
  logic               grant_en;

  // Winner selection: favoured owner while budget remains, else cyclic scan after ptr
  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (owner_q == IDX_W'(i)) owner_req = req[i];
    end
    owner_fav  = (state_q == OWN) && owner_req && (cnt_q < CW'(BURST_LEN));
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int k = 1; k <= int'(N); k++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!scan_found && req[i] && (((int'(ptr_q) + k) % int'(N)) == i)) begin
          scan_found = 1'b1;
          scan_idx   = IDX_W'(i);
        end
      end
    end
    win_idx  = owner_fav ? owner_q : scan_idx;
    grant_en = (|req) && !fifo_full && !reset;
  end

  always_comb begin
    gnt       = '0;
    fifo_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      gnt[i] = grant_en && (win_idx == IDX_W'(i));
      if (gnt[i]) fifo_data = req_data[i*DW +: DW];
    end
    fifo_push = |gnt;
  end

  // Tenure bookkeeping; a fifo_full stall with requests pending holds everything
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (grant_en) begin
      ptr_d = win_idx;
      if (owner_fav) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        owner_d = win_idx;
        cnt_d   = CW'(1);
        state_d = OWN;
      end
    end else if (!(|req)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(N); i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < int'(N); i++) begin
        if (gnt[i]) acc_q[i] <= acc_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    push_count = '0;
    for (int i = 0; i < int'(N); i++) push_count[i*CNT_W +: CNT_W] = acc_q[i];
  end

  assign owner_id    = owner_q;
  assign owner_valid = (state_q == OWN);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter with a behavioural 4-deep FIFO model.
module tb_fifo_push_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned BL    = 2;
  localparam int unsigned CNT_W = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req;
  logic [N*DW-1:0]    req_data;
  logic [N-1:0]       gnt;
  logic               fifo_full;
  logic               fifo_push;
  logic [DW-1:0]      fifo_data;
  logic [2:0]         owner_id;
  logic               owner_valid;
  logic [N*CNT_W-1:0] push_count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] outq[$];
  logic          pop_en;
  logic          stall;
  logic [N-1:0]  last_gnt;
  logic          last_push;
  logic [DW-1:0] last_data;

  fifo_push_arbiter #(.N(N), .DW(DW), .BURST_LEN(BL), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_data(fifo_data),
    .owner_id(owner_id), .owner_valid(owner_valid), .push_count(push_count)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] pc(input int i);
    return push_count[i*CNT_W +: CNT_W];
  endfunction

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  // One cycle from a negedge: sample grant, let the FIFO model pop/push at posedge
  task automatic step();
    fifo_full = (fq.size() >= 4) || stall;
    #1;
    last_gnt  = gnt;
    last_push = fifo_push;
    last_data = fifo_data;
    @(posedge clk);
    if (pop_en && fq.size() > 0) outq.push_back(fq.pop_front());
    if (last_push) fq.push_back(last_data);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; stall = 1'b0; pop_en = 1'b0; fifo_full = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b0;
    fq.delete();
    outq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '1; req_data = '1; fifo_full = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL reset_push: got %b want 0", fifo_push); end
    total++; if (fifo_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", fifo_data); end
    total++; if (owner_valid !== 1'b0) begin bad++; $display("FAIL reset_owner_valid: got %b want 0", owner_valid); end
    total++; if (owner_id !== 3'd0) begin bad++; $display("FAIL reset_owner_id: got %0d want 0", owner_id); end
    total++; if (push_count !== '0) begin bad++; $display("FAIL reset_push_count: got %h want 0", push_count); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    pop_en = 1'b1;
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      set_data(0, 32'hA0 + 32'(k));
      step();
      total++; if (last_gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt[%0d]: got %b want 0001", k, last_gnt); end
    end
    req = 4'b0000;
    step();
    total++; if (pc(0) !== 16'd5) begin bad++; $display("FAIL single_count: got %0d want 5", pc(0)); end
    total++; if (owner_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", owner_valid); end
    total++; if (outq.size() != 5) begin bad++; $display("FAIL single_outq_size: got %0d want 5", outq.size()); end
    for (int k = 0; k < 5 && k < outq.size(); k++) begin
      total++;
      if (outq[k] !== 32'hA0 + 32'(k)) begin
        bad++; $display("FAIL single_order[%0d]: got %h want %h", k, outq[k], 32'hA0 + 32'(k));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    logic [2:0]   exp_o [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
    do_reset();
    pop_en = 1'b1;
    for (int i = 0; i < 4; i++) set_data(i, 32'hC0 + 32'(i));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      total++; if (last_gnt !== exp_g[k]) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, last_gnt, exp_g[k]); end
      total++; if (owner_id !== exp_o[k]) begin bad++; $display("FAIL rr_owner[%0d]: got %0d want %0d", k, owner_id, exp_o[k]); end
      total++; if (last_data !== 32'hC0 + 32'(exp_o[k])) begin
        bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, last_data, 32'hC0 + 32'(exp_o[k]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp_g [4] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010};
    do_reset();
    set_data(0, 32'hB0);
    set_data(1, 32'hB1);
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (last_gnt !== exp_g[k]) begin bad++; $display("FAIL bp_fill[%0d]: got %b want %b", k, last_gnt, exp_g[k]); end
    end
    step();
    total++; if (last_gnt !== 4'b0000) begin bad++; $display("FAIL bp_full_gnt: got %b want 0000", last_gnt); end
    total++; if (last_push !== 1'b0) begin bad++; $display("FAIL bp_full_push: got %b want 0", last_push); end
    total++; if (owner_id !== 3'd1) begin bad++; $display("FAIL bp_owner_hold: got %0d want 1", owner_id); end
    total++; if (owner_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_hold: got %b want 1", owner_valid); end
    pop_en = 1'b1;
    step();
    total++; if (last_gnt !== 4'b0000) begin bad++; $display("FAIL bp_pop_gnt: got %b want 0000", last_gnt); end
    pop_en = 1'b0;
    step();
    total++; if (last_gnt !== 4'b0001) begin bad++; $display("FAIL bp_resume_gnt: got %b want 0001", last_gnt); end
    total++; if (owner_id !== 3'd0) begin bad++; $display("FAIL bp_resume_owner: got %0d want 0", owner_id); end
    pop_en = 1'b1;
    step();
    pop_en = 1'b0;
    step();
    // New tenure started at cnt=1, so requester 0 keeps the next slot
    total++; if (last_gnt !== 4'b0001) begin bad++; $display("FAIL bp_tenure_cnt: got %b want 0001", last_gnt); end
  endtask

  task automatic test_stall_mid_burst();
    do_reset();
    pop_en = 1'b1;
    set_data(0, 32'hD0);
    set_data(2, 32'hD2);
    req = 4'b0100;
    step();
    total++; if (last_gnt !== 4'b0100) begin bad++; $display("FAIL stall_first: got %b want 0100", last_gnt); end
    req = 4'b0101;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (last_gnt !== 4'b0000) begin bad++; $display("FAIL stall_gnt[%0d]: got %b want 0000", k, last_gnt); end
    end
    total++; if (owner_id !== 3'd2) begin bad++; $display("FAIL stall_owner: got %0d want 2", owner_id); end
    stall = 1'b0;
    step();
    total++; if (last_gnt !== 4'b0100) begin bad++; $display("FAIL stall_resume: got %b want 0100", last_gnt); end
    step();
    total++; if (last_gnt !== 4'b0001) begin bad++; $display("FAIL stall_rotate: got %b want 0001", last_gnt); end
    total++; if (pc(2) !== 16'd2) begin bad++; $display("FAIL stall_count: got %0d want 2", pc(2)); end
  endtask

  task automatic test_owner_drop();
    do_reset();
    pop_en = 1'b1;
    req = 4'b1010;
    step();
    total++; if (last_gnt !== 4'b0010) begin bad++; $display("FAIL drop_first: got %b want 0010", last_gnt); end
    req = 4'b1000;
    step();
    total++; if (last_gnt !== 4'b1000) begin bad++; $display("FAIL drop_next: got %b want 1000", last_gnt); end
    total++; if (owner_id !== 3'd3) begin bad++; $display("FAIL drop_owner: got %0d want 3", owner_id); end
    total++; if (owner_valid !== 1'b1) begin bad++; $display("FAIL drop_valid: got %b want 1", owner_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    pop_en = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 3; k++) step();
    total++; if (pc(0) !== 16'd2) begin bad++; $display("FAIL ar_pre_count0: got %0d want 2", pc(0)); end
    total++; if (pc(1) !== 16'd1) begin bad++; $display("FAIL ar_pre_count1: got %0d want 1", pc(1)); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL ar_gnt: got %b want 0000", gnt); end
    total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL ar_push: got %b want 0", fifo_push); end
    total++; if (owner_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", owner_valid); end
    for (int i = 0; i < 4; i++) begin
      total++; if (pc(i) !== 16'd0) begin bad++; $display("FAIL ar_count[%0d]: got %0d want 0", i, pc(i)); end
    end
    @(negedge clk);
    reset = 1'b0;
    fq.delete();
    step();
    total++; if (last_gnt !== 4'b0001) begin bad++; $display("FAIL ar_first_gnt: got %b want 0001", last_gnt); end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; pop_en = 1'b0; stall = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stall_mid_burst();
    test_owner_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
